day007_seg_scan_ctrl: RTL and testbench

DAY007_SEG_SCAN_CTRL -- requirements
Module: day007_seg_scan_ctrl

---
 rtl/day007_seg_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_day007_seg_scan_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/day007_seg_scan_ctrl.sv
// day007_seg_scan_ctrl
// Four-digit seven-segment scan controller. One shared bcd-to-7seg decoder is
// time-multiplexed across digits 0..3. Each digit slot lasts DIGIT_CYCLES
// cycles. The first BLANK_CYCLES cycles of each slot keep every anode off to
// prevent ghosting. New values are double-buffered. A loaded value waits in a
// shadow register and reaches the display only at a frame boundary, so a
// frame never tears.
//
// Ports:
//   clk_i      sole clock, rising edge
//   rst_i      synchronous active-high reset
//   load_i     single-cycle strobe, captures value_i
//   value_i    four BCD nibbles, [3:0] is digit 0 (rightmost)
//   bcd_o      nibble of the current digit for the shared decoder
//   an_o       active-low anode enables, bit n selects digit n
//   digit_o    index of the current slot
//   pending_o  a loaded value is waiting for the frame boundary
//   frame_o    one-cycle pulse on the last cycle of the digit-3 slot
//
// Optional feature: define LEADING_ZERO_BLANK_EN to keep the anodes of
// leading-zero digits (n > 0) off. Digit 0 is always driven.
//
// State table:
//   state | meaning
//   BLANK | first BLANK_CYCLES cycles of a slot, all anodes off
//   DRIVE | rest of the slot, anode of digit idx on

module day007_seg_scan_ctrl #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [15:0] value_i,
    output logic [3:0]  bcd_o,
    output logic [3:0]  an_o,
    output logic [1:0]  digit_o,
    output logic        pending_o,
    output logic        frame_o
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [1:0]       idx_q, idx_n;
    logic [15:0]      disp_q, disp_n;
    logic [15:0]      shadow_q, shadow_n;
    logic             pending_q, pending_n;
    logic [3:0]       an_n;
    logic [3:0]       bcd_n;
    logic             frame_n;
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0]       lz_n;
`endif

    // Next-state logic. The outputs are registered from the next-state values,
    // so each output flop holds the value of the registered state in the same
    // cycle. No combinational path runs from the inputs to the outputs.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        idx_n     = idx_q;
        disp_n    = disp_q;
        shadow_n  = shadow_q;
        pending_n = pending_q;

        case (state_q)
            BLANK: begin
                cnt_n = cnt_q + CNT_W'(1);
                if (cnt_q == BLANK_LAST) begin
                    state_n = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == DIGIT_LAST) begin
                    cnt_n   = '0;
                    idx_n   = idx_q + 2'd1;
                    state_n = BLANK;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = BLANK;
            end
        endcase

        // frame_o marks the current cycle as the last of the frame. A load on
        // that cycle bypasses the shadow and goes straight to the display.
        if (load_i) begin
            shadow_n = value_i;
            if (frame_o) begin
                disp_n    = value_i;
                pending_n = 1'b0;
            end else begin
                pending_n = 1'b1;
            end
        end else if (frame_o && pending_q) begin
            disp_n    = shadow_q;
            pending_n = 1'b0;
        end

        bcd_n   = disp_n[{idx_n, 2'b00} +: 4];
        frame_n = (idx_n == 2'd3) && (cnt_n == DIGIT_LAST);

`ifdef LEADING_ZERO_BLANK_EN
        // lz_n[n] is set when digit n and every digit above it are zero.
        lz_n[0] = 1'b0;
        lz_n[1] = (disp_n[15:4]  == 12'd0);
        lz_n[2] = (disp_n[15:8]  == 8'd0);
        lz_n[3] = (disp_n[15:12] == 4'd0);
        if (state_n == DRIVE && !lz_n[idx_n]) begin
            an_n = ~(4'b0001 << idx_n);
        end else begin
            an_n = 4'b1111;
        end
`else
        if (state_n == DRIVE) begin
            an_n = ~(4'b0001 << idx_n);
        end else begin
            an_n = 4'b1111;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            disp_q    <= 16'd0;
            shadow_q  <= 16'd0;
            pending_q <= 1'b0;
            an_o      <= 4'b1111;
            bcd_o     <= 4'd0;
            digit_o   <= 2'd0;
            frame_o   <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            idx_q     <= idx_n;
            disp_q    <= disp_n;
            shadow_q  <= shadow_n;
            pending_q <= pending_n;
            an_o      <= an_n;
            bcd_o     <= bcd_n;
            digit_o   <= idx_n;
            frame_o   <= frame_n;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: tb/tb_day007_seg_scan_ctrl.sv
module tb_day007_seg_scan_ctrl;

    localparam int DC    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * DC;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        load_i = 1'b0;
    logic [15:0] value_i = 16'd0;
    logic [3:0]  bcd_o;
    logic [3:0]  an_o;
    logic [1:0]  digit_o;
    logic        pending_o;
    logic        frame_o;

    day007_seg_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (load_i),
        .value_i   (value_i),
        .bcd_o     (bcd_o),
        .an_o      (an_o),
        .digit_o   (digit_o),
        .pending_o (pending_o),
        .frame_o   (frame_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
        logic [1:0] digit;
        logic       pend;
        logic       frame;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: m_t counts cycles since the last reset edge.
    int          m_t      = 0;
    logic [15:0] m_disp   = 16'd0;
    logic [15:0] m_shadow = 16'd0;
    logic        m_pend   = 1'b0;
    logic        m_valid  = 1'b0;

    function automatic exp_t expect_now();
        exp_t        e;
        int          slot;
        int          pos;
        logic [15:0] hi;
        slot = (m_t / DC) % 4;
        pos  = m_t % DC;
        hi   = m_disp >> (4 * slot);
        e.bcd   = hi[3:0];
        e.digit = 2'(slot);
        e.pend  = m_pend;
        e.frame = (slot == 3) && (pos == DC - 1);
        if (pos < BC) e.an = 4'b1111;
        else          e.an = ~(4'b0001 << slot);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && hi == 16'd0) e.an = 4'b1111;
`endif
        return e;
    endfunction

    task automatic step(input logic r, input logic l, input logic [15:0] v);
        logic frame_now;
        @(negedge clk_i);
        rst_i   = r;
        load_i  = l;
        value_i = v;
        if (r) begin
            m_t = 0; m_disp = 16'd0; m_shadow = 16'd0; m_pend = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            frame_now = ((m_t % FRAME) == FRAME - 1);
            if (l) begin
                m_shadow = v;
                if (frame_now) begin m_disp = v; m_pend = 1'b0; end
                else           m_pend = 1'b1;
            end else if (frame_now && m_pend) begin
                m_disp = m_shadow; m_pend = 1'b0;
            end
            m_t++;
        end
        if (m_valid) sb.push_back(expect_now());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0);
    endtask

    // Monitor: compares the DUT outputs with the queued expectation once per cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (an_o !== e.an || bcd_o !== e.bcd || digit_o !== e.digit ||
                    pending_o !== e.pend || frame_o !== e.frame) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t: got an=%b bcd=%h digit=%0d pend=%b frame=%b, expected an=%b bcd=%h digit=%0d pend=%b frame=%b",
                             $time, an_o, bcd_o, digit_o, pending_o, frame_o,
                             e.an, e.bcd, e.digit, e.pend, e.frame);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(1'b1, 1'b0, 16'd0);
        step(1'b1, 1'b0, 16'd0);
        idle(3);

        // Basic load, shown from the next frame.
        step(1'b0, 1'b1, 16'h1234);
        idle(2 * FRAME + 5);

        // Last load wins.
        step(1'b0, 1'b1, 16'h1111);
        idle(3);
        step(1'b0, 1'b1, 16'h2222);
        idle(2 * FRAME);

        // Load coincident with the frame pulse.
        for (int i = 0; i < FRAME + 2 && (m_t % FRAME) != FRAME - 1; i++) idle(1);
        step(1'b0, 1'b1, 16'h5678);
        idle(FRAME + 4);

        // Reset during the DRIVE part of digit 2, with a load pending.
        step(1'b0, 1'b1, 16'h9ABC);
        for (int i = 0; i < FRAME + 2 && !(((m_t / DC) % 4) == 2 && (m_t % DC) >= BC + 1); i++) idle(1);
        step(1'b1, 1'b0, 16'd0);
        idle(FRAME + 3);

        // Reset has priority over a simultaneous load.
        step(1'b0, 1'b1, 16'h4321);
        step(1'b1, 1'b1, 16'hABCD);
        idle(FRAME + 3);

        // Random traffic, including non-BCD nibbles and occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic r, l;
            r = ($urandom_range(0, 99) == 0);
            l = ($urandom_range(0, 9) == 0);
            step(r, l, 16'($urandom));
        end

        // Leading-zero patterns.
        step(1'b0, 1'b1, 16'h0050);
        idle(2 * FRAME + 2);
        step(1'b0, 1'b1, 16'h0000);
        idle(2 * FRAME + 2);
        step(1'b0, 1'b1, 16'hF00E);
        idle(2 * FRAME + 2);

        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
